// File: rtl/tick_hundredth_pkg.sv
// rtl/tick_hundredth_pkg.sv - default constants and divider helpers for tick_hundredth
//
// Purpose: shared constants and elaboration-time helpers for the tick_hundredth divider.
//   DEF_CLK_HZ  : default source clock frequency in Hz
//   DEF_TICK_HZ : default output square-wave frequency in Hz
//   calc_half   : cycles per half period of the output, CLK_HZ/(2*TICK_HZ)
//   calc_exact  : true when CLK_HZ divides evenly into whole half periods
//   calc_width  : counter width able to hold 0..HALF-1, at least 1 bit
package tick_hundredth_pkg;

    localparam int DEF_CLK_HZ  = 2000000;
    localparam int DEF_TICK_HZ = 100;

    // A zero or negative tick rate yields HALF = 0 so the top-level range
    // check rejects it instead of dividing by zero during elaboration.
    function automatic int calc_half(input int clk_hz, input int tick_hz);
        if (tick_hz < 1) begin
            return 0;
        end
        return clk_hz / (2 * tick_hz);
    endfunction

    function automatic bit calc_exact(input int clk_hz, input int tick_hz);
        if (tick_hz < 1) begin
            return 1'b0;
        end
        return (clk_hz % (2 * tick_hz)) == 0;
    endfunction

    function automatic int calc_width(input int half);
        if (half <= 1) begin
            return 1;
        end
        return $clog2(half);
    endfunction

endpackage

// File: rtl/tick_hundredth_cnt.sv
// rtl/tick_hundredth_cnt.sv - wrapping modulo-HALF counter with wrap strobe
//
// Purpose: counts 0..HALF-1 on every clock edge and flags the last count.
// Ports:
//   clk_i   : source clock
//   reset_i : asynchronous active-high reset, clears the count
//   wrap_o  : high while the count sits at HALF-1, i.e. the next edge wraps to 0
module tick_hundredth_cnt
    import tick_hundredth_pkg::*;
#(
    parameter int HALF = 10000,
    parameter int CW   = 14
) (
    input  logic clk_i,
    input  logic reset_i,
    output logic wrap_o
);

    localparam logic [CW-1:0] LAST = CW'(HALF - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Comparing against HALF-1 rather than letting the counter overflow keeps
    // the count strictly below HALF for any HALF, not just powers of two.
    assign wrap_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (wrap_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tick_hundredth.sv
// rtl/tick_hundredth.sv - divides clk_100Hz down to a 50%-duty square wave at TICK_HZ
//
// Purpose: generates a glitch-free clock-like square wave for downstream logic.
// Optional feature macro: TICK_HUNDREDTH_PULSE_EN adds the tick_pulse output.
// Ports:
//   clk_100Hz  : source clock (nominally 2 MHz), the only clock in the block
//   reset      : asynchronous active-high reset
//   clk_tick   : divided square wave, HALF cycles low then HALF cycles high
//   tick_pulse : (TICK_HUNDREDTH_PULSE_EN only) one-cycle strobe on each clk_tick rise
module tick_hundredth
    import tick_hundredth_pkg::*;
#(
    parameter int CLK_HZ  = DEF_CLK_HZ,
    parameter int TICK_HZ = DEF_TICK_HZ
) (
    input  logic clk_100Hz,
    input  logic reset,
    output logic clk_tick
`ifdef TICK_HUNDREDTH_PULSE_EN
    ,
    output logic tick_pulse
`endif
);

    localparam int HALF = calc_half(CLK_HZ, TICK_HZ);
    localparam int CW   = calc_width(HALF);

    generate
        if (!calc_exact(CLK_HZ, TICK_HZ) || HALF < 1) begin : g_bad_ratio
            $error("tick_hundredth: CLK_HZ must be a positive multiple of 2*TICK_HZ");
        end
    endgenerate

    logic wrap;
    logic clk_tick_q;
    logic clk_tick_d;

    tick_hundredth_cnt #(
        .HALF (HALF),
        .CW   (CW)
    ) u_cnt (
        .clk_i   (clk_100Hz),
        .reset_i (reset),
        .wrap_o  (wrap)
    );

    // Toggle on the same edge the counter wraps; the output is the flop itself
    // so downstream logic never sees a combinational glitch.
    assign clk_tick_d = clk_tick_q ^ wrap;

    always_ff @(posedge clk_100Hz or posedge reset) begin
        if (reset) begin
            clk_tick_q <= 1'b0;
        end else begin
            clk_tick_q <= clk_tick_d;
        end
    end

    assign clk_tick = clk_tick_q;

`ifdef TICK_HUNDREDTH_PULSE_EN
    logic tick_pulse_q;
    logic tick_pulse_d;

    // A wrap while clk_tick is low is exactly the edge on which it rises.
    assign tick_pulse_d = wrap & ~clk_tick_q;

    always_ff @(posedge clk_100Hz or posedge reset) begin
        if (reset) begin
            tick_pulse_q <= 1'b0;
        end else begin
            tick_pulse_q <= tick_pulse_d;
        end
    end

    assign tick_pulse = tick_pulse_q;
`endif

endmodule

// File: tb/tb_tick_hundredth.sv
// tb/tb_tick_hundredth.sv - self-checking bench for tick_hundredth
module tb_tick_hundredth;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_def;
    logic rst_small;
    logic tick_def;
    logic tick4;
    logic tick1;
`ifdef TICK_HUNDREDTH_PULSE_EN
    logic pulse_def;
    logic pulse4;
    logic pulse1;
`endif

    tick_hundredth dut_def (
        .clk_100Hz (clk),
        .reset     (rst_def),
        .clk_tick  (tick_def)
`ifdef TICK_HUNDREDTH_PULSE_EN
        ,
        .tick_pulse (pulse_def)
`endif
    );

    tick_hundredth #(.CLK_HZ(8), .TICK_HZ(1)) dut4 (
        .clk_100Hz (clk),
        .reset     (rst_small),
        .clk_tick  (tick4)
`ifdef TICK_HUNDREDTH_PULSE_EN
        ,
        .tick_pulse (pulse4)
`endif
    );

    tick_hundredth #(.CLK_HZ(2), .TICK_HZ(1)) dut1 (
        .clk_100Hz (clk),
        .reset     (rst_small),
        .clk_tick  (tick1)
`ifdef TICK_HUNDREDTH_PULSE_EN
        ,
        .tick_pulse (pulse1)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;
    int ecount = 0;

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b (edge %0d)", name, act, exp, ecount);
        end
    endtask

    // Advance to the given rising edge counted from the last release, then settle.
    task automatic goto_edge(input int target);
        repeat (target - ecount) @(posedge clk);
        ecount = target;
        #1;
    endtask

    typedef struct {
        logic rst;
        logic exp4;
        logic exp1;
    } vec_t;

    vec_t tbl[17];

    initial begin
        // HALF=4 follows 0000111100001111 from release; HALF=1 toggles each edge.
        tbl[0]  = '{1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b1};
        tbl[7]  = '{1'b0, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 1'b1};
        tbl[15] = '{1'b0, 1'b1, 1'b0};
        tbl[16] = '{1'b0, 1'b1, 1'b1};

        rst_def   = 1'b1;
        rst_small = 1'b1;
        #1;
        check("reset_def_tick", tick_def, 1'b0);
        check("reset_tick4", tick4, 1'b0);

        // Table phase: small instances; default instance held in reset throughout.
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            rst_small = tbl[i].rst;
            @(posedge clk);
            #1;
            check($sformatf("tbl%0d_tick4", i), tick4, tbl[i].exp4);
            check($sformatf("tbl%0d_tick1", i), tick1, tbl[i].exp1);
            check($sformatf("tbl%0d_def_held", i), tick_def, 1'b0);
        end

        // HALF=4 reset mid high phase, then restart from scratch.
        @(negedge clk);
        rst_small = 1'b1;
        #1;
        check("small_async_reset", tick4, 1'b0);
        @(negedge clk);
        rst_small = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("small_restart_e3", tick4, 1'b0);
        @(posedge clk);
        #1;
        check("small_restart_e4", tick4, 1'b1);

        // Default instance: first rise at edge 10000.
        @(negedge clk);
        rst_def = 1'b0;
        ecount = 0;
        goto_edge(1);
        check("def_e1", tick_def, 1'b0);
        goto_edge(9999);
        check("def_e9999", tick_def, 1'b0);
        goto_edge(10000);
        check("def_e10000", tick_def, 1'b1);
        goto_edge(15000);
        check("def_e15000", tick_def, 1'b1);

        // Asynchronous reset while high: output must drop before any clock edge.
        #2;
        rst_def = 1'b1;
        #1;
        check("def_async_reset", tick_def, 1'b0);
`ifdef TICK_HUNDREDTH_PULSE_EN
        check("def_async_reset_pulse", pulse_def, 1'b0);
`endif
        repeat (3) @(posedge clk);
        #1;
        check("def_reset_held", tick_def, 1'b0);

        @(negedge clk);
        rst_def = 1'b0;
        ecount = 0;
        goto_edge(9999);
        check("rel_e9999", tick_def, 1'b0);
`ifdef TICK_HUNDREDTH_PULSE_EN
        check("rel_e9999_pulse", pulse_def, 1'b0);
`endif
        goto_edge(10000);
        check("rel_e10000", tick_def, 1'b1);
`ifdef TICK_HUNDREDTH_PULSE_EN
        check("rel_e10000_pulse", pulse_def, 1'b1);
`endif
        goto_edge(10001);
        check("rel_e10001", tick_def, 1'b1);
`ifdef TICK_HUNDREDTH_PULSE_EN
        check("rel_e10001_pulse", pulse_def, 1'b0);
`endif
        goto_edge(19999);
        check("rel_e19999", tick_def, 1'b1);
        goto_edge(20000);
        check("rel_e20000", tick_def, 1'b0);
`ifdef TICK_HUNDREDTH_PULSE_EN
        check("rel_e20000_pulse", pulse_def, 1'b0);
`endif
        goto_edge(29999);
        check("rel_e29999", tick_def, 1'b0);
        goto_edge(30000);
        check("rel_e30000", tick_def, 1'b1);
`ifdef TICK_HUNDREDTH_PULSE_EN
        check("rel_e30000_pulse", pulse_def, 1'b1);
`endif
        goto_edge(30001);
`ifdef TICK_HUNDREDTH_PULSE_EN
        check("rel_e30001_pulse", pulse_def, 1'b0);
`endif
        check("rel_e30001", tick_def, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
